divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 25 ++
 rtl/divider_seq.sv | 162 ++++++++++++++++
 tb/tb_divider_seq.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: FSM state type shared by the sequential divider.
// The FIX state exists only when DIVIDER_SEQ_SIGNED_EN is defined.
package div_pkg;

`ifdef DIVIDER_SEQ_SIGNED_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract step.
// The partial remainder is shifted left with the next dividend bit and
// compared against the divisor on WIDTH+1 bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             next_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    // Shift in the next bit and subtract the divisor when it fits.
    // When it fits, the difference is below the divisor, so the low WIDTH
    // bits of the subtraction are exact.
    always_comb begin
        shifted = {rem_in, next_bit};
        q_bit   = (shifted >= {1'b0, divisor});
        rem_out = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring divider, one quotient bit per cycle.
// Optional macro DIVIDER_SEQ_SIGNED_EN adds signed_op and a FIX state that
// applies result signs after dividing operand magnitudes.
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DIVIDER_SEQ_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             q_bit;
    logic [WIDTH-1:0] mag_dividend;
    logic [WIDTH-1:0] mag_divisor;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic sgn_q;
    logic neg_q_q;
    logic neg_r_q;
    logic neg_q_in;
    logic neg_r_in;

    // Magnitudes to divide and result sign corrections, decided at accept.
    always_comb begin
        neg_r_in     = signed_op & dividend[WIDTH-1];
        neg_q_in     = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        mag_dividend = neg_r_in ? -dividend : dividend;
        mag_divisor  = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
    end
`else
    // Unsigned build divides the raw operands.
    always_comb begin
        mag_dividend = dividend;
        mag_divisor  = divisor;
    end
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .divisor (dvs_q),
        .next_bit(quo_q[WIDTH-1]),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // Dividend bits leave at the top of quo_q while quotient bits enter at the bottom.
    always_comb begin
        quo_next = {quo_q[WIDTH-2:0], q_bit};
    end

    // Control FSM with registered ready/done/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ready     <= 1'b1;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
`ifdef DIVIDER_SEQ_SIGNED_EN
            sgn_q     <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        if (divisor == '0) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            div_zero  <= 1'b1;
                            quotient  <= '1;
                            remainder <= dividend;
                        end else begin
                            state    <= RUN;
                            div_zero <= 1'b0;
                            rem_q    <= '0;
                            cnt      <= '0;
                            quo_q    <= mag_dividend;
                            dvs_q    <= mag_divisor;
`ifdef DIVIDER_SEQ_SIGNED_EN
                            sgn_q    <= signed_op;
                            neg_q_q  <= neg_q_in;
                            neg_r_q  <= neg_r_in;
`endif
                        end
                    end
                end
                RUN: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
`ifdef DIVIDER_SEQ_SIGNED_EN
                        if (sgn_q) begin
                            state <= FIX;
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= quo_next;
                            remainder <= rem_next;
                        end
`else
                        state     <= DONE;
                        done      <= 1'b1;
                        quotient  <= quo_next;
                        remainder <= rem_next;
`endif
                    end
                end
`ifdef DIVIDER_SEQ_SIGNED_EN
                FIX: begin
                    state     <= DONE;
                    done      <= 1'b1;
                    quotient  <= neg_q_q ? -quo_q : quo_q;
                    remainder <= neg_r_q ? -rem_q : rem_q;
                end
`endif
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: self-checking bench for divider_seq (WIDTH=32 and WIDTH=8).
// Signed scenarios are compiled in when DIVIDER_SEQ_SIGNED_EN is defined.
module tb_divider_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start32 = 1'b0;
    logic [31:0] dividend32 = '0;
    logic [31:0] divisor32 = '0;
    logic        ready32, done32, div_zero32;
    logic [31:0] quotient32, remainder32;

    logic        start8 = 1'b0;
    logic [7:0]  dividend8 = '0;
    logic [7:0]  divisor8 = '0;
    logic        ready8, done8, div_zero8;
    logic [7:0]  quotient8, remainder8;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic signed_op32 = 1'b0;
    logic signed_op8 = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    divider_seq #(.WIDTH(32)) u_dut32 (
        .clk      (clk),
        .rst      (rst),
        .start    (start32),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_op(signed_op32),
`endif
        .dividend (dividend32),
        .divisor  (divisor32),
        .ready    (ready32),
        .done     (done32),
        .quotient (quotient32),
        .remainder(remainder32),
        .div_zero (div_zero32)
    );

    divider_seq #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start8),
`ifdef DIVIDER_SEQ_SIGNED_EN
        .signed_op(signed_op8),
`endif
        .dividend (dividend8),
        .divisor  (divisor8),
        .ready    (ready8),
        .done     (done8),
        .quotient (quotient8),
        .remainder(remainder8),
        .div_zero (div_zero8)
    );

    // Launch one 32-bit division once ready; latency counts the cycle after the accepting edge as 1.
    task automatic go32(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output logic [31:0] q, output logic [31:0] r, output logic dz,
                        output int lat, output int idle_wait);
        idle_wait = 0;
        while (!ready32 && idle_wait < 100) begin
            @(posedge clk); #1;
            idle_wait++;
        end
        dividend32 = a;
        divisor32  = b;
`ifdef DIVIDER_SEQ_SIGNED_EN
        signed_op32 = sgn;
`else
        if (sgn) $display("note: signed request issued to unsigned build");
`endif
        start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient32;
        r  = remainder32;
        dz = div_zero32;
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dz,
                       output int lat, output int idle_wait);
        idle_wait = 0;
        while (!ready8 && idle_wait < 100) begin
            @(posedge clk); #1;
            idle_wait++;
        end
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q  = quotient8;
        r  = remainder8;
        dz = div_zero8;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ready32 !== 1'b1) begin n_err++; $display("FAIL reset_ready32: got %b want 1", ready32); end
        n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL reset_done32: got %b want 0", done32); end
        n_cmp++; if (quotient32 !== 32'd0) begin n_err++; $display("FAIL reset_q32: got %h want 0", quotient32); end
        n_cmp++; if (remainder32 !== 32'd0) begin n_err++; $display("FAIL reset_r32: got %h want 0", remainder32); end
        n_cmp++; if (div_zero32 !== 1'b0) begin n_err++; $display("FAIL reset_dz32: got %b want 0", div_zero32); end
        n_cmp++; if (ready8 !== 1'b1 || done8 !== 1'b0 || quotient8 !== 8'd0 || remainder8 !== 8'd0 || div_zero8 !== 1'b0) begin
            n_err++; $display("FAIL reset_w8: got rdy=%b done=%b q=%h r=%h dz=%b want 1 0 0 0 0", ready8, done8, quotient8, remainder8, div_zero8);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] q, r;
        logic dz;
        int lat, iw;
        go32(32'd100, 32'd7, 1'b0, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'd14) begin n_err++; $display("FAIL d100_7_q: got %0d want 14", q); end
        n_cmp++; if (r !== 32'd2) begin n_err++; $display("FAIL d100_7_r: got %0d want 2", r); end
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL d100_7_dz: got %b want 0", dz); end
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL d100_7_lat: got %0d want 33", lat); end
        @(posedge clk); #1;
        n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done32); end
        go32(32'd5, 32'd0, 1'b0, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL d5_0_q: got %h want ffffffff", q); end
        n_cmp++; if (r !== 32'd5) begin n_err++; $display("FAIL d5_0_r: got %0d want 5", r); end
        n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL d5_0_dz: got %b want 1", dz); end
        n_cmp++; if (lat != 1) begin n_err++; $display("FAIL d5_0_lat: got %0d want 1", lat); end
    endtask

    task automatic test_ignore_start();
        int lat, iw, ready_high;
        iw = 0;
        while (!ready32 && iw < 100) begin @(posedge clk); #1; iw++; end
        dividend32 = 32'd100;
        divisor32  = 32'd7;
        start32    = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        ready_high = 0;
        while (!done32 && lat < 200) begin
            if (ready32) ready_high++;
            if (lat == 6) begin
                dividend32 = 32'd9;
                divisor32  = 32'd3;
                start32    = 1'b1;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start32 = 1'b0;
        n_cmp++; if (ready_high != 0) begin n_err++; $display("FAIL busy_ready: got %0d ready cycles want 0", ready_high); end
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL busy_lat: got %0d want 33", lat); end
        n_cmp++; if (quotient32 !== 32'd14 || remainder32 !== 32'd2) begin
            n_err++; $display("FAIL busy_result: got %0d r %0d want 14 r 2", quotient32, remainder32);
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (ready32 !== 1'b1 || done32 !== 1'b0) begin
            n_err++; $display("FAIL busy_no_second_op: got rdy=%b done=%b want 1 0", ready32, done32);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] q, r;
        logic dz;
        int lat, iw, done_seen;
        iw = 0;
        while (!ready32 && iw < 100) begin @(posedge clk); #1; iw++; end
        dividend32 = 32'd100;
        divisor32  = 32'd7;
        start32    = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (ready32 !== 1'b1 || done32 !== 1'b0 || div_zero32 !== 1'b0 || quotient32 !== 32'd0 || remainder32 !== 32'd0) begin
            n_err++; $display("FAIL abort_state: got rdy=%b done=%b dz=%b q=%h r=%h want 1 0 0 0 0",
                              ready32, done32, div_zero32, quotient32, remainder32);
        end
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32) done_seen++;
        end
        n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", done_seen); end
        go32(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'hFFFF_FFFF || r !== 32'd0 || dz !== 1'b0) begin
            n_err++; $display("FAIL max_div_1: got %h r %h dz %b want ffffffff r 0 dz 0", q, r, dz);
        end
        n_cmp++; if (lat != 33) begin n_err++; $display("FAIL max_div_1_lat: got %0d want 33", lat); end
    endtask

    task automatic test_random32();
        logic [31:0] a, b, q, r, eq, er;
        logic dz, edz;
        int lat, iw, elat;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = a + 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF; er = a; edz = 1'b1; elat = 1;
            end else begin
                eq = a / b; er = a % b; edz = 1'b0; elat = 33;
            end
            go32(a, b, 1'b0, q, r, dz, lat, iw);
            n_cmp++; if (q !== eq || r !== er || dz !== edz) begin
                n_err++; $display("FAIL rnd32 %h/%h: got %h r %h dz %b want %h r %h dz %b", a, b, q, r, dz, eq, er, edz);
            end
            n_cmp++; if (lat != elat) begin n_err++; $display("FAIL rnd32_lat %h/%h: got %0d want %0d", a, b, lat, elat); end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            n_cmp++; if (quotient32 !== eq || remainder32 !== er || div_zero32 !== edz) begin
                n_err++; $display("FAIL rnd32_hold %h/%h: got %h r %h dz %b want %h r %h dz %b",
                                  a, b, quotient32, remainder32, div_zero32, eq, er, edz);
            end
        end
    endtask

    task automatic test_width8_back_to_back();
        logic [7:0] a, b, q, r, eq, er;
        logic dz;
        int lat, iw;
        go8(8'd255, 8'd16, q, r, dz, lat, iw);
        n_cmp++; if (q !== 8'd15 || r !== 8'd15 || dz !== 1'b0) begin
            n_err++; $display("FAIL w8_255_16: got %0d r %0d dz %b want 15 r 15 dz 0", q, r, dz);
        end
        n_cmp++; if (lat != 9) begin n_err++; $display("FAIL w8_255_16_lat: got %0d want 9", lat); end
        go8(8'd8, 8'd3, q, r, dz, lat, iw);
        n_cmp++; if (iw != 1) begin n_err++; $display("FAIL w8_b2b_gap: got %0d cycles want 1", iw); end
        n_cmp++; if (q !== 8'd2 || r !== 8'd2 || lat != 9) begin
            n_err++; $display("FAIL w8_8_3: got %0d r %0d lat %0d want 2 r 2 lat 9", q, r, lat);
        end
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            eq = (b == 8'd0) ? 8'hFF : a / b;
            er = (b == 8'd0) ? a : a % b;
            go8(a, b, q, r, dz, lat, iw);
            n_cmp++; if (q !== eq || r !== er || dz !== (b == 8'd0) || lat != ((b == 8'd0) ? 1 : 9)) begin
                n_err++; $display("FAIL rnd8 %h/%h: got %h r %h dz %b lat %0d want %h r %h", a, b, q, r, dz, lat, eq, er);
            end
        end
    endtask

`ifdef DIVIDER_SEQ_SIGNED_EN
    task automatic test_signed();
        logic [31:0] a, b, q, r, eq, er;
        logic dz;
        int lat, iw;
        longint sa, sb, q64, r64;
        go32(-32'sd7, 32'd2, 1'b1, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || dz !== 1'b0) begin
            n_err++; $display("FAIL s_m7_2: got %h r %h dz %b want fffffffd r ffffffff dz 0", q, r, dz);
        end
        n_cmp++; if (lat != 34) begin n_err++; $display("FAIL s_m7_2_lat: got %0d want 34", lat); end
        go32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin
            n_err++; $display("FAIL s_minneg: got %h r %h dz %b want 80000000 r 0 dz 0", q, r, dz);
        end
        go32(-32'sd7, 32'd2, 1'b0, q, r, dz, lat, iw);
        n_cmp++; if (q !== 32'h7FFF_FFFC || r !== 32'd1 || lat != 33) begin
            n_err++; $display("FAIL s_unsigned_op: got %h r %h lat %0d want 7ffffffc r 1 lat 33", q, r, lat);
        end
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            if (b == 32'd0) begin
                eq = 32'hFFFF_FFFF; er = a;
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q64 = sa / sb;
                r64 = sa % sb;
                eq = q64[31:0];
                er = r64[31:0];
            end
            go32(a, b, 1'b1, q, r, dz, lat, iw);
            n_cmp++; if (q !== eq || r !== er || dz !== (b == 32'd0) || lat != ((b == 32'd0) ? 1 : 34)) begin
                n_err++; $display("FAIL s_rnd %h/%h: got %h r %h dz %b lat %0d want %h r %h", a, b, q, r, dz, lat, eq, er);
            end
        end
        signed_op32 = 1'b0;
    endtask
`endif

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_random32();
        test_width8_back_to_back();
`ifdef DIVIDER_SEQ_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
